// File: rtl/tpu_pkg.sv
// Shared types and widths for the TPU slot scheduler and its interrupt timer.
package tpu_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int TPU_SLOT_W  = 8;
    localparam int TPU_TIMER_W = 16;

endpackage

// File: rtl/tpu_int_timer.sv
// Periodic TPU timer: free-running count while the scheduler runs, a hit compare
// against the programmed period, and the sticky int_flag.
module tpu_int_timer
    import tpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   srst,
    input  logic                   run,
    input  logic [TPU_TIMER_W-1:0] period,
    input  logic                   int_clr,
    output logic                   int_flag
);

    localparam logic [TPU_TIMER_W-1:0] TIMER_ONE = {{(TPU_TIMER_W-1){1'b0}}, 1'b1};

    logic [TPU_TIMER_W-1:0] timer_cnt_r;
    logic [TPU_TIMER_W-1:0] timer_nxt_s;
    logic                   int_flag_r;
    logic                   flag_nxt_s;
    logic                   hit_s;

    // Hit compare plus next count and flag; a hit beats a coincident clear.
    always_comb begin
        hit_s       = 1'b0;
        timer_nxt_s = timer_cnt_r;
        flag_nxt_s  = int_flag_r;
        if (srst || !run) begin
            timer_nxt_s = {TPU_TIMER_W{1'b0}};
            flag_nxt_s  = 1'b0;
        end else begin
            // >= rather than == so a period lowered below the count still fires.
            hit_s = (period != {TPU_TIMER_W{1'b0}}) && (timer_cnt_r >= (period - TIMER_ONE));
            if (hit_s || (period == {TPU_TIMER_W{1'b0}})) begin
                timer_nxt_s = {TPU_TIMER_W{1'b0}};
            end else begin
                timer_nxt_s = timer_cnt_r + TIMER_ONE;
            end
            if (hit_s) begin
                flag_nxt_s = 1'b1;
            end else if (int_clr) begin
                flag_nxt_s = 1'b0;
            end else begin
                flag_nxt_s = int_flag_r;
            end
        end
    end

    // Timer and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_cnt_r <= {TPU_TIMER_W{1'b0}};
            int_flag_r  <= 1'b0;
        end else begin
            timer_cnt_r <= timer_nxt_s;
            int_flag_r  <= flag_nxt_s;
        end
    end

    assign int_flag = int_flag_r;

endmodule

// File: rtl/tpu_slot_sched.sv
// TDMA slot scheduler: IDLE/RUN sequencing, cycle and slot counters, per-slot
// TX/RX windows with start strobes, and the masked timer interrupt.
module tpu_slot_sched
    import tpu_pkg::*;
#(
    parameter  int SLOT_CYCLES = 256,
    parameter  int NUM_SLOTS   = 256,
    localparam int CYC_W       = $clog2(SLOT_CYCLES)
) (
    input  logic                   SYS_CLK,
    input  logic                   SYS_RST_N,
    input  logic                   RSTTPU,
    input  logic                   TXSLOT_EN,
    input  logic                   RXSLOT_EN,
    input  logic [TPU_SLOT_W-1:0]  TX_SLOT,
    input  logic [TPU_SLOT_W-1:0]  RX_SLOT,
    input  logic                   TIMERINTMSK,
    input  logic [TPU_TIMER_W-1:0] TIMER_INT_VALUE,
    input  logic                   int_clr,
    output logic                   tpu_active,
    output logic [TPU_SLOT_W-1:0]  slot_num,
    output logic [CYC_W-1:0]       cyc_cnt,
    output logic                   frame_start,
    output logic                   tx_win,
    output logic                   rx_win,
    output logic                   tx_start,
    output logic                   rx_start,
    output logic                   int_flag,
    output logic                   irq
);

    localparam logic [CYC_W-1:0]      CYC_LAST  = CYC_W'(SLOT_CYCLES - 1);
    localparam logic [CYC_W-1:0]      CYC_ONE   = CYC_W'(1);
    localparam logic [TPU_SLOT_W-1:0] SLOT_LAST = TPU_SLOT_W'(NUM_SLOTS - 1);
    localparam logic [TPU_SLOT_W-1:0] SLOT_ONE  = TPU_SLOT_W'(1);

    state_t                  state_r;
    state_t                  state_s;
    logic [CYC_W-1:0]        cyc_r;
    logic [CYC_W-1:0]        cyc_s;
    logic [TPU_SLOT_W-1:0]   slot_r;
    logic [TPU_SLOT_W-1:0]   slot_s;
    logic                    active_s;
    logic                    frame_start_r;
    logic                    frame_start_s;
    logic                    tx_win_r;
    logic                    tx_win_s;
    logic                    rx_win_r;
    logic                    rx_win_s;
    logic                    tx_start_r;
    logic                    tx_start_s;
    logic                    rx_start_r;
    logic                    rx_start_s;
    logic                    boundary_s;
    logic                    tx_match_s;
    logic                    rx_match_s;

    // FSM state register.
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state: the soft reset alone decides between IDLE and RUN.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!RSTTPU) state_s = RUN;
                else         state_s = IDLE;
            end
            RUN: begin
                if (RSTTPU) state_s = IDLE;
                else        state_s = RUN;
            end
            default: state_s = IDLE;
        endcase
    end

    // Next output values; entering RUN is treated as a slot boundary into slot 0.
    always_comb begin
        boundary_s    = (state_r == IDLE) || (cyc_r == CYC_LAST);
        cyc_s         = {CYC_W{1'b0}};
        slot_s        = {TPU_SLOT_W{1'b0}};
        active_s      = 1'b0;
        frame_start_s = 1'b0;
        tx_win_s      = 1'b0;
        rx_win_s      = 1'b0;
        tx_start_s    = 1'b0;
        rx_start_s    = 1'b0;
        tx_match_s    = 1'b0;
        rx_match_s    = 1'b0;
        if (state_s == RUN) begin
            active_s = 1'b1;
            if (state_r == IDLE) begin
                cyc_s  = {CYC_W{1'b0}};
                slot_s = {TPU_SLOT_W{1'b0}};
            end else if (cyc_r == CYC_LAST) begin
                cyc_s  = {CYC_W{1'b0}};
                slot_s = (slot_r == SLOT_LAST) ? {TPU_SLOT_W{1'b0}} : (slot_r + SLOT_ONE);
            end else begin
                cyc_s  = cyc_r + CYC_ONE;
                slot_s = slot_r;
            end
            tx_match_s    = TXSLOT_EN && (slot_s == TX_SLOT);
            rx_match_s    = RXSLOT_EN && (slot_s == RX_SLOT);
            frame_start_s = boundary_s && (slot_s == {TPU_SLOT_W{1'b0}});
            if (boundary_s) begin
                tx_win_s   = tx_match_s;
                rx_win_s   = rx_match_s;
                tx_start_s = tx_match_s;
                rx_start_s = rx_match_s;
            end else begin
                tx_win_s   = tx_win_r && TXSLOT_EN;
                rx_win_s   = rx_win_r && RXSLOT_EN;
                tx_start_s = 1'b0;
                rx_start_s = 1'b0;
            end
        end else begin
            active_s = 1'b0;
        end
    end

    // Registered scheduler outputs.
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            cyc_r         <= {CYC_W{1'b0}};
            slot_r        <= {TPU_SLOT_W{1'b0}};
            tpu_active    <= 1'b0;
            frame_start_r <= 1'b0;
            tx_win_r      <= 1'b0;
            rx_win_r      <= 1'b0;
            tx_start_r    <= 1'b0;
            rx_start_r    <= 1'b0;
        end else begin
            cyc_r         <= cyc_s;
            slot_r        <= slot_s;
            tpu_active    <= active_s;
            frame_start_r <= frame_start_s;
            tx_win_r      <= tx_win_s;
            rx_win_r      <= rx_win_s;
            tx_start_r    <= tx_start_s;
            rx_start_r    <= rx_start_s;
        end
    end

    tpu_int_timer u_int_timer (
        .clk      (SYS_CLK),
        .rst_n    (SYS_RST_N),
        .srst     (RSTTPU),
        .run      (state_r == RUN),
        .period   (TIMER_INT_VALUE),
        .int_clr  (int_clr),
        .int_flag (int_flag)
    );

    assign cyc_cnt     = cyc_r;
    assign slot_num    = slot_r;
    assign frame_start = frame_start_r;
    assign tx_win      = tx_win_r;
    assign rx_win      = rx_win_r;
    assign tx_start    = tx_start_r;
    assign rx_start    = rx_start_r;
    assign irq         = int_flag && TIMERINTMSK;

endmodule

// File: tb/tb_tpu_slot_sched.sv
// Directed bench for tpu_slot_sched (4 cycles x 4 slots) with a per-cycle
// reference model feeding an expected-output queue.
module tb_tpu_slot_sched;

    logic        SYS_CLK = 1'b0;
    logic        SYS_RST_N;
    logic        RSTTPU;
    logic        TXSLOT_EN;
    logic        RXSLOT_EN;
    logic [7:0]  TX_SLOT;
    logic [7:0]  RX_SLOT;
    logic        TIMERINTMSK;
    logic [15:0] TIMER_INT_VALUE;
    logic        int_clr;
    logic        tpu_active;
    logic [7:0]  slot_num;
    logic [1:0]  cyc_cnt;
    logic        frame_start;
    logic        tx_win;
    logic        rx_win;
    logic        tx_start;
    logic        rx_start;
    logic        int_flag;
    logic        irq;

    typedef struct packed {
        logic       act;
        logic [7:0] slot;
        logic [1:0] cyc;
        logic       fs;
        logic       txw;
        logic       rxw;
        logic       txs;
        logic       rxs;
        logic       flag;
        logic       irq;
    } out_t;

    out_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    bit   m_run   = 1'b0;
    int   m_n     = 0;
    int   m_cyc   = 0;
    int   m_slot  = 0;
    int   m_timer = 0;
    bit   m_flag  = 1'b0;
    bit   m_txw   = 1'b0;
    bit   m_rxw   = 1'b0;
    bit   m_txs   = 1'b0;
    bit   m_rxs   = 1'b0;
    bit   m_fs    = 1'b0;

    tpu_slot_sched #(
        .SLOT_CYCLES (4),
        .NUM_SLOTS   (4)
    ) dut (
        .SYS_CLK         (SYS_CLK),
        .SYS_RST_N       (SYS_RST_N),
        .RSTTPU          (RSTTPU),
        .TXSLOT_EN       (TXSLOT_EN),
        .RXSLOT_EN       (RXSLOT_EN),
        .TX_SLOT         (TX_SLOT),
        .RX_SLOT         (RX_SLOT),
        .TIMERINTMSK     (TIMERINTMSK),
        .TIMER_INT_VALUE (TIMER_INT_VALUE),
        .int_clr         (int_clr),
        .tpu_active      (tpu_active),
        .slot_num        (slot_num),
        .cyc_cnt         (cyc_cnt),
        .frame_start     (frame_start),
        .tx_win          (tx_win),
        .rx_win          (rx_win),
        .tx_start        (tx_start),
        .rx_start        (rx_start),
        .int_flag        (int_flag),
        .irq             (irq)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit model_hit();
        return m_run && (TIMER_INT_VALUE != 16'd0) && (m_timer >= int'(TIMER_INT_VALUE) - 1);
    endfunction

    function automatic out_t observed();
        return {tpu_active, slot_num, cyc_cnt, frame_start, tx_win, rx_win,
                tx_start, rx_start, int_flag, irq};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Predict the outputs after the next edge, push them, clock, then compare.
    task automatic step();
        out_t e;
        out_t o;
        bit   hit;
        bit   was_run;
        bit   bnd;
        bit   txm;
        bit   rxm;
        hit     = model_hit();
        was_run = m_run;
        if (!SYS_RST_N || RSTTPU) begin
            m_run = 1'b0; m_n = 0; m_timer = 0; m_flag = 1'b0;
            m_txw = 1'b0; m_rxw = 1'b0; m_txs = 1'b0; m_rxs = 1'b0; m_fs = 1'b0;
            m_cyc = 0; m_slot = 0;
        end else begin
            if (was_run) begin
                m_timer = (hit || TIMER_INT_VALUE == 16'd0) ? 0 : m_timer + 1;
                if (hit) m_flag = 1'b1;
                else if (int_clr) m_flag = 1'b0;
                m_n++;
            end else begin
                m_n = 0; m_timer = 0; m_flag = 1'b0;
            end
            m_run  = 1'b1;
            m_cyc  = m_n % 4;
            m_slot = (m_n / 4) % 4;
            bnd    = (m_cyc == 0);
            txm    = TXSLOT_EN && (int'(TX_SLOT) == m_slot);
            rxm    = RXSLOT_EN && (int'(RX_SLOT) == m_slot);
            m_txw  = bnd ? txm : (m_txw && TXSLOT_EN);
            m_rxw  = bnd ? rxm : (m_rxw && RXSLOT_EN);
            m_txs  = bnd && txm;
            m_rxs  = bnd && rxm;
            m_fs   = (m_n % 16) == 0;
        end
        e.act  = m_run;
        e.slot = 8'(m_slot);
        e.cyc  = 2'(m_cyc);
        e.fs   = m_fs;
        e.txw  = m_txw;
        e.rxw  = m_rxw;
        e.txs  = m_txs;
        e.rxs  = m_rxs;
        e.flag = m_flag;
        e.irq  = m_flag && TIMERINTMSK;
        exp_q.push_back(e);
        @(posedge SYS_CLK);
        #1;
        o = observed();
        e = exp_q.pop_front();
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL cycle_outputs n=%0d observed=%b expected=%b", m_n, o, e);
        end
    endtask

    initial begin
        int cnt;
        int cnt2;
        int cnt3;
        int first;
        SYS_RST_N       = 1'b0;
        RSTTPU          = 1'b0;
        TXSLOT_EN       = 1'b1;
        RXSLOT_EN       = 1'b1;
        TX_SLOT         = 8'd2;
        RX_SLOT         = 8'd2;
        TIMERINTMSK     = 1'b0;
        TIMER_INT_VALUE = 16'd0;
        int_clr         = 1'b0;
        #2;
        check("reset_outputs", 32'(observed()), 32'd0);
        step();
        step();
        SYS_RST_N = 1'b1;

        // Two frames with TX and RX both on slot 2.
        cnt = 0; cnt2 = 0; cnt3 = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            cnt  += int'(tx_win);
            cnt2 += int'(tx_start);
            cnt3 += int'(frame_start);
        end
        check("tx_win_cycles", 32'(cnt), 32'd8);
        check("tx_start_pulses", 32'(cnt2), 32'd2);
        check("frame_start_pulses", 32'(cnt3), 32'd2);

        // Disable mid-slot aborts the window.
        for (int i = 0; i < 64 && !(m_slot == 2 && m_cyc == 1); i++) step();
        TXSLOT_EN = 1'b0;
        step();
        check("tx_drop_win", 32'(tx_win), 32'd0);
        check("rx_kept_win", 32'(rx_win), 32'd1);

        // Enable mid-slot waits for the next frame's slot 2.
        for (int i = 0; i < 64 && !(m_slot == 2 && m_cyc == 1); i++) step();
        TXSLOT_EN = 1'b1;
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (m_slot == 2 && m_cyc == 0) break;
            cnt += int'(tx_win);
        end
        check("tx_raise_no_win", 32'(cnt), 32'd0);
        check("tx_raise_next_win", 32'(tx_win), 32'd1);

        // Timer from a fresh RUN entry.
        RSTTPU = 1'b1;
        step();
        RSTTPU          = 1'b0;
        TIMER_INT_VALUE = 16'd5;
        first = 0;
        for (int k = 1; k <= 20 && first == 0; k++) begin
            step();
            if (int_flag === 1'b1) first = k;
        end
        check("first_flag_cycle", 32'(first), 32'd6);
        check("irq_masked", 32'(irq), 32'd0);
        TIMERINTMSK = 1'b1;
        #1;
        check("irq_unmask_same_cycle", 32'(irq), 32'd1);
        for (int i = 0; i < 20 && !model_hit(); i++) step();
        int_clr = 1'b1;
        step();
        int_clr = 1'b0;
        check("clr_vs_hit_set_wins", 32'(int_flag), 32'd1);
        int_clr = 1'b1;
        step();
        int_clr = 1'b0;
        check("clr_alone", 32'(int_flag), 32'd0);

        // Soft reset in slot 3 with the flag set.
        for (int i = 0; i < 64 && !(m_slot == 3 && m_flag); i++) step();
        check("pre_srst_flag", 32'(int_flag), 32'd1);
        RSTTPU = 1'b1;
        step();
        check("srst_all_zero", 32'(observed()), 32'd0);
        RSTTPU = 1'b0;
        step();
        check("restart_frame_start", 32'(frame_start), 32'd1);
        check("restart_slot", 32'(slot_num), 32'd0);

        // Out-of-range TX slot never opens a window.
        TX_SLOT = 8'd7;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            cnt += int'(tx_win);
        end
        check("tx_slot_out_of_range", 32'(cnt), 32'd0);

        // Period 0 disables the timer.
        TIMER_INT_VALUE = 16'd0;
        int_clr = 1'b1;
        step();
        int_clr = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            cnt += int'(int_flag);
        end
        check("period0_no_hits", 32'(cnt), 32'd0);

        // Period 1 hits every cycle, so a continuous clear never wins.
        TIMER_INT_VALUE = 16'd1;
        int_clr = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            cnt += int'(int_flag);
        end
        int_clr = 1'b0;
        check("period1_every_cycle", 32'(cnt), 32'd10);

        // Asynchronous reset mid-frame.
        TIMER_INT_VALUE = 16'd3;
        for (int i = 0; i < 6; i++) step();
        #3;
        SYS_RST_N = 1'b0;
        #1;
        check("async_reset_zero", 32'(observed()), 32'd0);
        step();
        SYS_RST_N = 1'b1;
        for (int i = 0; i < 20; i++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
